// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, result broadcast and issue bus of the reservation station
interface reservation_station_if;
  // dispatch from the reorder buffer
  logic [4:0]  op_in;
  logic [2:0]  target;
  logic [31:0] value1_in;
  logic [31:0] value2_in;
  logic [2:0]  query1_in;
  logic [2:0]  query2_in;
  logic [31:0] imm_in;
  // result broadcasts
  logic [2:0]  alu_num;
  logic [31:0] alu_value;
  logic [2:0]  mem_num;
  logic [31:0] mem_value;
  // status and issue
  logic        rs_full;
  logic        rs_overflow;
  logic        alu_valid;
  logic [4:0]  alu_op;
  logic [31:0] alu_v1;
  logic [31:0] alu_v2;
  logic [31:0] alu_imm;
  logic [2:0]  alu_dest;

  modport master (
    output op_in, target, value1_in, value2_in, query1_in, query2_in, imm_in,
    output alu_num, alu_value, mem_num, mem_value,
    input  rs_full, rs_overflow, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_dest
  );

  modport slave (
    input  op_in, target, value1_in, value2_in, query1_in, query2_in, imm_in,
    input  alu_num, alu_value, mem_num, mem_value,
    output rs_full, rs_overflow, alu_valid, alu_op, alu_v1, alu_v2, alu_imm, alu_dest
  );
endinterface

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - ALU reservation station with operand wakeup and in-order-by-slot issue
module reservation_station #(
  parameter int ENTRIES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reservation_station_if.slave bus
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);

  // slot storage
  logic        busy_q [ENTRIES];
  logic [4:0]  op_q   [ENTRIES];
  logic [31:0] v1_q   [ENTRIES];
  logic [31:0] v2_q   [ENTRIES];
  logic [2:0]  q1_q   [ENTRIES];
  logic [2:0]  q2_q   [ENTRIES];
  logic [31:0] imm_q  [ENTRIES];
  logic [2:0]  dest_q [ENTRIES];

  logic        busy_d [ENTRIES];
  logic [4:0]  op_d   [ENTRIES];
  logic [31:0] v1_d   [ENTRIES];
  logic [31:0] v2_d   [ENTRIES];
  logic [2:0]  q1_d   [ENTRIES];
  logic [2:0]  q2_d   [ENTRIES];
  logic [31:0] imm_d  [ENTRIES];
  logic [2:0]  dest_d [ENTRIES];

  // registered outputs
  logic        alu_valid_q, alu_valid_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [31:0] alu_v1_q, alu_v1_d;
  logic [31:0] alu_v2_q, alu_v2_d;
  logic [31:0] alu_imm_q, alu_imm_d;
  logic [2:0]  alu_dest_q, alu_dest_d;
  logic        rs_full_q, rs_full_d;
  logic        rs_overflow_q, rs_overflow_d;

  logic          accept;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic          iss_found;
  logic [IW-1:0] iss_idx;
  logic [CW-1:0] busy_cnt;

  // ops executed by the ALU; memory ops, LUI, AUIPC, JAL and the idle code bypass the station
  function automatic logic op_accepted(input logic [4:0] op);
    return (op <= 5'd13) || (op == 5'd17) || (op == 5'd26) || (op == 5'd27);
  endfunction

  // tag after snooping both broadcasts; ALU broadcast wins when both match
  function automatic logic [2:0] snoop_tag(input logic [2:0] q, input logic [2:0] an,
                                           input logic [2:0] mn);
    if ((an != 3'd0) && (q == an)) return 3'd0;
    if ((mn != 3'd0) && (q == mn)) return 3'd0;
    return q;
  endfunction

  function automatic logic [31:0] snoop_val(input logic [2:0] q, input logic [31:0] v,
                                            input logic [2:0] an, input logic [31:0] av,
                                            input logic [2:0] mn, input logic [31:0] mv);
    if ((an != 3'd0) && (q == an)) return av;
    if ((mn != 3'd0) && (q == mn)) return mv;
    return v;
  endfunction

  assign accept = (bus.target != 3'd0) && op_accepted(bus.op_in);

  // pick lowest free slot and lowest ready slot from pre-edge state
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (busy_q[i] && (q1_q[i] == 3'd0) && (q2_q[i] == 3'd0)) begin
        iss_found = 1'b1;
        iss_idx   = IW'(i);
      end
    end
  end

  // slot next state: issue clears, wakeup snoops, dispatch fills a slot that was free pre-edge
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      busy_d[i] = busy_q[i];
      op_d[i]   = op_q[i];
      v1_d[i]   = v1_q[i];
      v2_d[i]   = v2_q[i];
      q1_d[i]   = q1_q[i];
      q2_d[i]   = q2_q[i];
      imm_d[i]  = imm_q[i];
      dest_d[i] = dest_q[i];
      if (busy_q[i]) begin
        v1_d[i] = snoop_val(q1_q[i], v1_q[i], bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
        q1_d[i] = snoop_tag(q1_q[i], bus.alu_num, bus.mem_num);
        v2_d[i] = snoop_val(q2_q[i], v2_q[i], bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
        q2_d[i] = snoop_tag(q2_q[i], bus.alu_num, bus.mem_num);
      end
      if (iss_found && (iss_idx == IW'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (accept && free_found && (free_idx == IW'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = bus.op_in;
        v1_d[i]   = snoop_val(bus.query1_in, bus.value1_in, bus.alu_num, bus.alu_value,
                              bus.mem_num, bus.mem_value);
        q1_d[i]   = snoop_tag(bus.query1_in, bus.alu_num, bus.mem_num);
        v2_d[i]   = snoop_val(bus.query2_in, bus.value2_in, bus.alu_num, bus.alu_value,
                              bus.mem_num, bus.mem_value);
        q2_d[i]   = snoop_tag(bus.query2_in, bus.alu_num, bus.mem_num);
        imm_d[i]  = bus.imm_in;
        dest_d[i] = bus.target;
      end
    end
  end

  // occupancy after this edge drives back-pressure with one slot of slack
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_cnt = busy_cnt + CW'(busy_d[i]);
    end
    rs_full_d     = (busy_cnt >= CW'(ENTRIES - 1));
    rs_overflow_d = rs_overflow_q | (accept & ~free_found);
  end

  // issue outputs: strobe for one cycle, payload holds between issues
  always_comb begin
    alu_valid_d = iss_found;
    alu_op_d    = alu_op_q;
    alu_v1_d    = alu_v1_q;
    alu_v2_d    = alu_v2_q;
    alu_imm_d   = alu_imm_q;
    alu_dest_d  = alu_dest_q;
    if (iss_found) begin
      alu_op_d   = op_q[iss_idx];
      alu_v1_d   = v1_q[iss_idx];
      alu_v2_d   = v2_q[iss_idx];
      alu_imm_d  = imm_q[iss_idx];
      alu_dest_d = dest_q[iss_idx];
    end
  end

  // state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_q[i] <= 1'b0;
        op_q[i]   <= 5'h1f;
        v1_q[i]   <= '0;
        v2_q[i]   <= '0;
        q1_q[i]   <= '0;
        q2_q[i]   <= '0;
        imm_q[i]  <= '0;
        dest_q[i] <= '0;
      end
      alu_valid_q   <= 1'b0;
      alu_op_q      <= 5'h1f;
      alu_v1_q      <= '0;
      alu_v2_q      <= '0;
      alu_imm_q     <= '0;
      alu_dest_q    <= '0;
      rs_full_q     <= 1'b0;
      rs_overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_q[i] <= busy_d[i];
        op_q[i]   <= op_d[i];
        v1_q[i]   <= v1_d[i];
        v2_q[i]   <= v2_d[i];
        q1_q[i]   <= q1_d[i];
        q2_q[i]   <= q2_d[i];
        imm_q[i]  <= imm_d[i];
        dest_q[i] <= dest_d[i];
      end
      alu_valid_q   <= alu_valid_d;
      alu_op_q      <= alu_op_d;
      alu_v1_q      <= alu_v1_d;
      alu_v2_q      <= alu_v2_d;
      alu_imm_q     <= alu_imm_d;
      alu_dest_q    <= alu_dest_d;
      rs_full_q     <= rs_full_d;
      rs_overflow_q <= rs_overflow_d;
    end
  end

  assign bus.alu_valid   = alu_valid_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.alu_v1      = alu_v1_q;
  assign bus.alu_v2      = alu_v2_q;
  assign bus.alu_imm     = alu_imm_q;
  assign bus.alu_dest    = alu_dest_q;
  assign bus.rs_full     = rs_full_q;
  assign bus.rs_overflow = rs_overflow_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed and randomized bench for reservation_station against a slot-list model
module tb_reservation_station;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  reservation_station_if bus ();

  reservation_station #(.ENTRIES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          busy;
    logic [4:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [2:0]  q1;
    logic [2:0]  q2;
    logic [31:0] imm;
    logic [2:0]  dest;
  } slot_t;

  slot_t       m [4];
  logic        e_valid;
  logic [4:0]  e_op;
  logic [31:0] e_v1, e_v2, e_imm;
  logic [2:0]  e_dest;
  logic        e_full;
  logic        e_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i].busy = 0;
    e_valid = 0; e_op = 5'h1f; e_v1 = 0; e_v2 = 0; e_imm = 0; e_dest = 0;
    e_full = 0; e_ovf = 0;
  endtask

  // operand as seen after this edge's broadcasts
  task automatic resolve(inout logic [2:0] q, inout logic [31:0] v);
    if (bus.alu_num != 0 && q == bus.alu_num) begin v = bus.alu_value; q = 0; end
    else if (bus.mem_num != 0 && q == bus.mem_num) begin v = bus.mem_value; q = 0; end
  endtask

  task automatic model_step();
    int rdy;
    int fr;
    int cnt;
    bit acc;
    slot_t s;
    if (rst) begin
      model_reset();
      return;
    end
    rdy = -1;
    fr = -1;
    foreach (m[i]) begin
      if (rdy < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) rdy = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    e_valid = (rdy >= 0);
    if (rdy >= 0) begin
      e_op = m[rdy].op; e_v1 = m[rdy].v1; e_v2 = m[rdy].v2;
      e_imm = m[rdy].imm; e_dest = m[rdy].dest;
      m[rdy].busy = 0;
    end
    foreach (m[i]) if (m[i].busy) begin
      resolve(m[i].q1, m[i].v1);
      resolve(m[i].q2, m[i].v2);
    end
    acc = (bus.target != 0) && (bus.op_in inside {[5'd0:5'd13], 5'd17, 5'd26, 5'd27});
    if (acc) begin
      if (fr >= 0) begin
        s.busy = 1; s.op = bus.op_in; s.imm = bus.imm_in; s.dest = bus.target;
        s.q1 = bus.query1_in; s.v1 = bus.value1_in;
        s.q2 = bus.query2_in; s.v2 = bus.value2_in;
        resolve(s.q1, s.v1);
        resolve(s.q2, s.v2);
        m[fr] = s;
      end else begin
        e_ovf = 1;
      end
    end
    cnt = 0;
    foreach (m[i]) cnt += int'(m[i].busy);
    e_full = (cnt >= 3);
  endtask

  task automatic compare_all();
    chk("alu_valid", 32'(bus.alu_valid), 32'(e_valid));
    chk("alu_op", 32'(bus.alu_op), 32'(e_op));
    chk("alu_v1", bus.alu_v1, e_v1);
    chk("alu_v2", bus.alu_v2, e_v2);
    chk("alu_imm", bus.alu_imm, e_imm);
    chk("alu_dest", 32'(bus.alu_dest), 32'(e_dest));
    chk("rs_full", 32'(bus.rs_full), 32'(e_full));
    chk("rs_overflow", 32'(bus.rs_overflow), 32'(e_ovf));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    bus.op_in = 5'h1f; bus.target = 0;
    bus.value1_in = 0; bus.value2_in = 0; bus.query1_in = 0; bus.query2_in = 0; bus.imm_in = 0;
    bus.alu_num = 0; bus.alu_value = 0; bus.mem_num = 0; bus.mem_value = 0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [2:0] t, input logic [31:0] a,
                      input logic [31:0] b, input logic [2:0] qa, input logic [2:0] qb,
                      input logic [31:0] im);
    bus.op_in = op; bus.target = t; bus.value1_in = a; bus.value2_in = b;
    bus.query1_in = qa; bus.query2_in = qb; bus.imm_in = im;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // ready ADD issues one edge after dispatch
    disp(5'b00000, 3'd3, 32'd5, 32'd7, 3'd0, 3'd0, 32'h11);
    step();
    chk("add_not_yet", 32'(bus.alu_valid), 32'd0);
    idle();
    step();
    chk("add_valid", 32'(bus.alu_valid), 32'd1);
    chk("add_op", 32'(bus.alu_op), 32'd0);
    chk("add_v1", bus.alu_v1, 32'd5);
    chk("add_v2", bus.alu_v2, 32'd7);
    chk("add_dest", 32'(bus.alu_dest), 32'd3);
    step();
    chk("add_one_cycle", 32'(bus.alu_valid), 32'd0);

    // SUB waits on tag 5 from the ALU broadcast
    disp(5'b00001, 3'd2, 32'd0, 32'd9, 3'd5, 3'd0, 32'd0);
    step();
    idle();
    step();
    chk("sub_waits", 32'(bus.alu_valid), 32'd0);
    bus.alu_num = 3'd5; bus.alu_value = 32'h10;
    step();
    chk("sub_wake_edge", 32'(bus.alu_valid), 32'd0);
    idle();
    step();
    chk("sub_valid", 32'(bus.alu_valid), 32'd1);
    chk("sub_v1", bus.alu_v1, 32'h10);
    chk("sub_dest", 32'(bus.alu_dest), 32'd2);

    // dispatch-time bypass from the memory broadcast
    disp(5'b00010, 3'd1, 32'd3, 32'd0, 3'd0, 3'd4, 32'd0);
    bus.mem_num = 3'd4; bus.mem_value = 32'hABCD;
    step();
    idle();
    step();
    chk("byp_valid", 32'(bus.alu_valid), 32'd1);
    chk("byp_v2", bus.alu_v2, 32'hABCD);

    // LW and JAL never occupy a slot
    disp(5'b10100, 3'd6, 32'd1, 32'd2, 3'd0, 3'd0, 32'd4);
    step();
    disp(5'b10000, 3'd7, 32'd1, 32'd2, 3'd0, 3'd0, 32'd8);
    step();
    idle();
    step();
    chk("ignored_valid", 32'(bus.alu_valid), 32'd0);

    // fill, full, overflow, then drain in slot order
    for (int k = 1; k <= 5; k++) begin
      disp(5'b00011, 3'(k), 32'(k), 32'd0, 3'd6, 3'd0, 32'd0);
      step();
      if (k == 2) chk("full_after2", 32'(bus.rs_full), 32'd0);
      if (k == 3) chk("full_after3", 32'(bus.rs_full), 32'd1);
      if (k == 4) chk("ovf_after4", 32'(bus.rs_overflow), 32'd0);
      if (k == 5) chk("ovf_after5", 32'(bus.rs_overflow), 32'd1);
    end
    idle();
    bus.alu_num = 3'd6; bus.alu_value = 32'h66;
    step();
    idle();
    step();
    chk("drain_first_dest", 32'(bus.alu_dest), 32'd1);
    for (int k = 0; k < 4; k++) step();
    chk("ovf_sticky", 32'(bus.rs_overflow), 32'd1);

    // asynchronous reset between dispatch and issue
    for (int k = 1; k <= 3; k++) begin
      disp(5'b00100, 3'(k), 32'd0, 32'd0, 3'd7, 3'd0, 32'd0);
      step();
    end
    disp(5'b00000, 3'd4, 32'd1, 32'd2, 3'd0, 3'd0, 32'd0);
    step();
    chk("pre_rst_full", 32'(bus.rs_full), 32'd1);
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_valid", 32'(bus.alu_valid), 32'd0);
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    chk("rst_ovf", 32'(bus.rs_overflow), 32'd0);
    chk("rst_op", 32'(bus.alu_op), 32'h1f);
    compare_all();
    step();
    rst = 1'b0;
    step();
    chk("no_issue_after_rst", 32'(bus.alu_valid), 32'd0);
    disp(5'b00101, 3'd6, 32'd8, 32'd9, 3'd0, 3'd0, 32'd1);
    step();
    idle();
    step();
    chk("post_rst_dest", 32'(bus.alu_dest), 32'd6);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] ops [12];
      ops = '{5'd0, 5'd3, 5'd7, 5'd13, 5'd17, 5'd26, 5'd27, 5'd14, 5'd16, 5'd20, 5'd24, 5'd31};
      rst = ($urandom_range(0, 79) == 0);
      disp(ops[$urandom_range(0, 11)], 3'($urandom_range(0, 7)), $urandom, $urandom,
           ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7)),
           ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7)), $urandom);
      bus.alu_num   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.alu_value = $urandom;
      bus.mem_num   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      bus.mem_value = $urandom;
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
